plusarg_watchdog: RTL and testbench

- Consumes the 1-bit enable produced by a plusarg reader instance, e.g. +watchdog.
- When enabled, counts consecutive cycles without a progress pulse and raises a sticky trip flag once the programmable limit is reached.
- Sits directly downstream of the plusarg reader in the test harness. Its outputs drive harness fail/finish logic.
- Under SYNTHESIS the plusarg input is tied 0, so the block settles in DISABLED.

---
 rtl/plusarg_watchdog.sv | 141 ++++++++++++++
 tb/tb_plusarg_watchdog.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plusarg_watchdog.sv
// Idle-cycle watchdog enabled by a plusarg reader. After a reset holdoff it
// samples plusarg_en once. If that sample is 0 the block parks in DISABLED.
// If it is 1 the block counts consecutive cycles without progress and
// latches a sticky trip when the count reaches limit.
//
// Ports:
//   clock       sole clock
//   reset_n     asynchronous active-low reset
//   plusarg_en  enable from the plusarg reader (sampled once, after holdoff)
//   limit       idle-cycle limit; 0 disables tripping
//   progress    forward-progress pulse; zeroes the idle count
//   clear       restarts counting and acknowledges a trip
//   armed       1 while ARMED
//   tripped     sticky, 1 while TRIPPED
//   trip_pulse  one-cycle pulse on entry to TRIPPED
//   idle_count  current consecutive idle-cycle count
module plusarg_watchdog #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned HOLDOFF = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             plusarg_en,
   input  logic [CNT_W-1:0] limit,
   input  logic             progress,
   input  logic             clear,
   output logic             armed,
   output logic             tripped,
   output logic             trip_pulse,
   output logic [CNT_W-1:0] idle_count
);

   localparam int unsigned HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF - 1);

   // Reject a zero holdoff at elaboration.
   if (HOLDOFF < 1) begin : g_holdoff_check
      $error("plusarg_watchdog: HOLDOFF must be >= 1");
   end

   typedef enum logic [1:0] {
      S_HOLDOFF  = 2'd0,
      S_DISABLED = 2'd1,
      S_ARMED    = 2'd2,
      S_TRIPPED  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [HO_W-1:0]  r_ho_cnt;
   logic [HO_W-1:0]  w_ho_cnt_nxt;
   logic [CNT_W-1:0] r_idle;
   logic [CNT_W-1:0] w_idle_nxt;
   logic [CNT_W-1:0] w_idle_inc;
   logic             w_trip_entry;
   logic             r_armed;
   logic             r_tripped;
   logic             r_trip_pulse;

   // Saturating increment of the idle count.
   always_comb begin
      w_idle_inc = (&r_idle) ? r_idle : r_idle + CNT_W'(1);
   end

   // Next-state and next-count logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_ho_cnt_nxt = r_ho_cnt;
      w_idle_nxt   = r_idle;
      w_trip_entry = 1'b0;
      case (r_state)
         S_HOLDOFF: begin
            if (r_ho_cnt == HO_LAST) begin
               w_idle_nxt = '0;
               // X on the enable falls to DISABLED, as does an explicit 0.
               w_state_nxt = (plusarg_en === 1'b1) ? S_ARMED : S_DISABLED;
            end else begin
               w_ho_cnt_nxt = r_ho_cnt + HO_W'(1);
            end
         end
         S_DISABLED: begin
            w_state_nxt = S_DISABLED;
         end
         S_ARMED: begin
            if (clear || progress) begin
               w_idle_nxt = '0;
            end else begin
               w_idle_nxt = w_idle_inc;
               // Equality only: a limit lowered below the count never trips.
               if ((limit != '0) && (w_idle_inc == limit)) begin
                  w_state_nxt  = S_TRIPPED;
                  w_trip_entry = 1'b1;
               end
            end
         end
         S_TRIPPED: begin
            if (clear) begin
               w_idle_nxt  = '0;
               w_state_nxt = S_ARMED;
            end
         end
         default: begin
            w_state_nxt = S_HOLDOFF;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_HOLDOFF;
         r_ho_cnt     <= '0;
         r_idle       <= '0;
         r_armed      <= 1'b0;
         r_tripped    <= 1'b0;
         r_trip_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ho_cnt     <= w_ho_cnt_nxt;
         r_idle       <= w_idle_nxt;
         r_armed      <= (w_state_nxt == S_ARMED);
         r_tripped    <= (w_state_nxt == S_TRIPPED);
         r_trip_pulse <= w_trip_entry;
      end
   end

`ifndef SYNTHESIS
   // Announce each trip; the harness decides what to do about it.
   always_ff @(posedge clock) begin
      if (reset_n && w_trip_entry) begin
         $display("plusarg_watchdog: tripped at time %0t, limit %0d", $time, limit);
      end
   end
`endif

   assign armed      = r_armed;
   assign tripped    = r_tripped;
   assign trip_pulse = r_trip_pulse;
   assign idle_count = r_idle;

endmodule

// File: tb/tb_plusarg_watchdog.sv
module tb_plusarg_watchdog;

   logic        clock;
   logic        reset_n;
   logic        plusarg_en;
   logic [31:0] limit;
   logic [3:0]  limit4;
   logic        progress;
   logic        clear;

   logic        armed, tripped, trip_pulse;
   logic [31:0] idle_count;
   logic        armed4, tripped4, trip_pulse4;
   logic [3:0]  idle_count4;

   int n_cmp;
   int n_err;

   assign limit4 = limit[3:0];

   plusarg_watchdog #(.CNT_W(32), .HOLDOFF(16)) dut (
      .clock(clock), .reset_n(reset_n), .plusarg_en(plusarg_en),
      .limit(limit), .progress(progress), .clear(clear),
      .armed(armed), .tripped(tripped), .trip_pulse(trip_pulse),
      .idle_count(idle_count)
   );

   plusarg_watchdog #(.CNT_W(4), .HOLDOFF(16)) dut4 (
      .clock(clock), .reset_n(reset_n), .plusarg_en(plusarg_en),
      .limit(limit4), .progress(progress), .clear(clear),
      .armed(armed4), .tripped(tripped4), .trip_pulse(trip_pulse4),
      .idle_count(idle_count4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Assert reset for one edge, release at posedge+1 and check outputs during reset.
   task automatic apply_reset(input logic en);
      plusarg_en = en;
      progress   = 1'b0;
      clear      = 1'b0;
      reset_n    = 1'b0;
      tick();
      n_cmp++;
      if ({armed, tripped, trip_pulse, idle_count} !== 35'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got a=%b t=%b p=%b idle=%0d want all 0",
                  armed, tripped, trip_pulse, idle_count);
      end
      reset_n = 1'b1;
   endtask

   // Step through the holdoff: armed must stay low 15 edges and reflect en on the 16th.
   task automatic run_holdoff(input logic en);
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 15 || i == 16) begin
            n_cmp++;
            if (armed !== ((i == 16) ? en : 1'b0)) begin
               n_err++;
               $display("FAIL holdoff_edge%0d: armed=%b want %b", i, armed,
                        (i == 16) ? en : 1'b0);
            end
         end
      end
      n_cmp++;
      if (idle_count !== 32'd0) begin
         n_err++;
         $display("FAIL holdoff_idle: idle=%0d want 0", idle_count);
      end
   endtask

   task automatic test_reset();
      plusarg_en = 1'b1;
      limit      = 32'd5;
      apply_reset(1'b1);
   endtask

   task automatic test_disabled();
      int bad;
      limit = 32'd5;
      apply_reset(1'b0);
      bad = 0;
      for (int i = 0; i < 116; i++) begin
         // Toggle inputs to show they are ignored once disabled.
         plusarg_en = (i > 40);
         progress   = (i % 7 == 0);
         clear      = (i % 11 == 0);
         tick();
         if (armed !== 1'b0 || tripped !== 1'b0 || trip_pulse !== 1'b0 ||
             idle_count !== 32'd0)
            bad++;
      end
      progress = 1'b0;
      clear    = 1'b0;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL disabled_path: %0d cycles with nonzero outputs, want 0", bad);
      end
   endtask

   task automatic check_trip_sequence(input string tag);
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_cmp++;
         if (tripped !== 1'b0 || armed !== 1'b1 || idle_count !== 32'(k)) begin
            n_err++;
            $display("FAIL %s_count%0d: t=%b a=%b idle=%0d want t=0 a=1 idle=%0d",
                     tag, k, tripped, armed, idle_count, k);
         end
      end
      tick();
      n_cmp++;
      if (tripped !== 1'b1 || trip_pulse !== 1'b1 || armed !== 1'b0 ||
          idle_count !== 32'd5) begin
         n_err++;
         $display("FAIL %s_trip: t=%b p=%b a=%b idle=%0d want t=1 p=1 a=0 idle=5",
                  tag, tripped, trip_pulse, armed, idle_count);
      end
      progress = 1'b1;
      tick();
      progress = 1'b0;
      n_cmp++;
      if (tripped !== 1'b1 || trip_pulse !== 1'b0 || idle_count !== 32'd5) begin
         n_err++;
         $display("FAIL %s_sticky: t=%b p=%b idle=%0d want t=1 p=0 idle=5",
                  tag, tripped, trip_pulse, idle_count);
      end
      for (int k = 0; k < 5; k++) tick();
      n_cmp++;
      if (tripped !== 1'b1 || idle_count !== 32'd5) begin
         n_err++;
         $display("FAIL %s_frozen: t=%b idle=%0d want t=1 idle=5",
                  tag, tripped, idle_count);
      end
   endtask

   task automatic test_basic_trip();
      limit = 32'd5;
      apply_reset(1'b1);
      run_holdoff(1'b1);
      check_trip_sequence("basic");
   endtask

   task automatic test_clear_rearm();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_cmp++;
      if (armed !== 1'b1 || tripped !== 1'b0 || idle_count !== 32'd0) begin
         n_err++;
         $display("FAIL clear_rearm: a=%b t=%b idle=%0d want a=1 t=0 idle=0",
                  armed, tripped, idle_count);
      end
      check_trip_sequence("rearm");
   endtask

   task automatic test_progress_race();
      int exp_idle;
      int bad;
      int max_idle;
      clear = 1'b1;
      tick();
      clear    = 1'b0;
      exp_idle = 0;
      bad      = 0;
      max_idle = 0;
      for (int i = 0; i < 200; i++) begin
         progress = (exp_idle == 4);
         tick();
         exp_idle = progress ? 0 : exp_idle + 1;
         if (tripped !== 1'b0 || idle_count !== 32'(exp_idle)) bad++;
         if (int'(idle_count) > max_idle) max_idle = int'(idle_count);
      end
      progress = 1'b0;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL progress_race: %0d bad cycles, want 0", bad);
      end
      n_cmp++;
      if (max_idle != 4) begin
         n_err++;
         $display("FAIL progress_race_max: max idle=%0d want 4", max_idle);
      end
   endtask

   task automatic test_limit0_saturation();
      limit = 32'd0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      n_cmp++;
      if (idle_count4 !== 4'd15 || tripped4 !== 1'b0 || armed4 !== 1'b1) begin
         n_err++;
         $display("FAIL sat4: idle=%0d t=%b a=%b want idle=15 t=0 a=1",
                  idle_count4, tripped4, armed4);
      end
      n_cmp++;
      if (idle_count !== 32'd40 || tripped !== 1'b0) begin
         n_err++;
         $display("FAIL limit0_wide: idle=%0d t=%b want idle=40 t=0",
                  idle_count, tripped);
      end
   endtask

   task automatic test_async_reset();
      limit = 32'd5;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++;
      if (idle_count !== 32'd3 || armed !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset: idle=%0d a=%b want idle=3 a=1", idle_count, armed);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({armed, tripped, trip_pulse, idle_count} !== 35'd0) begin
         n_err++;
         $display("FAIL async_reset: a=%b t=%b p=%b idle=%0d want all 0",
                  armed, tripped, trip_pulse, idle_count);
      end
      tick();
      reset_n = 1'b1;
      run_holdoff(1'b1);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset_n    = 1'b1;
      plusarg_en = 1'b0;
      limit      = 32'd5;
      progress   = 1'b0;
      clear      = 1'b0;
      #3;
      test_reset();
      test_disabled();
      test_basic_trip();
      test_clear_rearm();
      test_progress_race();
      test_limit0_saturation();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
